sy_clint_reg_arb: RTL and testbench
===================================

SY_CLINT_REG_ARB -- requirements
Module: sy_clint_reg_arb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 64, the register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, the register data width.
REQ-003 The block SHALL have parameter REQ_NUM, default 2, the number of requesters (legal range 1..16).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req_valid_i, input, [REQ_NUM-1:0]: per-requester request valid.
REQ-007 The block SHALL have port req_ready_o, output, [REQ_NUM-1:0]: per-requester request accepted.
REQ-008 The block SHALL have port req_we_i, input, [REQ_NUM-1:0]: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr_i, input, [REQ_NUM-1:0][ADDR_WIDTH-1:0]: request address.
REQ-010 The block SHALL have port req_wdata_i, input, [REQ_NUM-1:0][DATA_WIDTH-1:0]: write data.
REQ-011 The block SHALL have port resp_valid_o, output, [REQ_NUM-1:0]: response valid.
REQ-012 The block SHALL have port resp_ready_i, input, [REQ_NUM-1:0]: response accepted.
REQ-013 The block SHALL have port resp_rdata_o, output, [DATA_WIDTH-1:0]: response data, shared by all requesters.
REQ-014 The block SHALL have ports reg_en_o (output, 1), reg_we_o (output, 1), reg_addr_o (output, ADDR_WIDTH), reg_wdata_o (output, DATA_WIDTH) and reg_rdata_i (input, DATA_WIDTH), forming the downstream register port of the CLINT register file; reg_rdata_i is valid in the same cycle as reg_en_o.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-016 In IDLE with any req_valid_i set, the block SHALL grant exactly one requester by round-robin, searching from index rr_ptr upward with wrap, and pulse that requester's req_ready_o for one cycle.
REQ-017 On the grant cycle, the block SHALL latch grant index, we, addr and wdata, and move to ACCESS.
REQ-018 In ACCESS, the block SHALL drive reg_en_o=1 with the latched we/addr/wdata for exactly one cycle, capture reg_rdata_i for reads (0 for writes), and move to RESP.
REQ-019 In RESP, the block SHALL assert resp_valid_o only for the granted index and hold it, along with a stable resp_rdata_o, until resp_ready_i for that index is 1.
REQ-020 On the RESP handshake, the block SHALL set rr_ptr to (grant+1) mod REQ_NUM and return to IDLE.
REQ-021 Latency SHALL be: request accepted in cycle 0, reg_en_o in cycle 1, resp_valid_o first in cycle 2; peak throughput SHALL be one access per 3 cycles.
REQ-022 Writes SHALL also return a response, with resp_rdata_o=0.
REQ-023 req_ready_o SHALL be 0 in ACCESS and RESP; a req_valid_i arriving then SHALL wait, without being lost, until the next IDLE.
REQ-024 With one requester valid, that requester SHALL be granted regardless of rr_ptr.
REQ-025 reg_en_o, reg_we_o, reg_addr_o and reg_wdata_o SHALL be 0 outside ACCESS.
REQ-026 A requester dropping req_valid_i before grant SHALL simply not be granted; the block SHALL never issue a downstream access without a prior req handshake.

Reset
REQ-027 On rst_i=1 at a clock edge, the block SHALL enter IDLE, set rr_ptr to 0, clear the latched request and read data, and drive all outputs to 0.
REQ-028 Reset in ACCESS or RESP SHALL abort the transaction: no response delivered and no further downstream strobe.

Structure
REQ-029 The state enum (IDLE/ACCESS/RESP) SHALL live in shared package sy_clint_pkg.
REQ-030 The round-robin pick (valid vector plus pointer in, one-hot grant and index out) SHALL be sub-module sy_rr_pick, which is purely combinational.
REQ-031 The grant index width SHALL be 1 when REQ_NUM==1, otherwise $clog2(REQ_NUM).

Verification
REQ-032 Single read: requester 0 reads 0xBFF8 while reg_rdata_i=0x1234 -> reg_en_o in cycle 1, resp_valid_o[0] in cycle 2 with rdata 0x1234.
REQ-033 Contention: both requesters valid continuously, rr_ptr=0 -> grants alternate 0,1,0,1, each with no gap beyond 3 cycles.
REQ-034 Backpressure: resp_ready_i[1]=0 for 5 cycles -> resp_valid_o[1] and rdata stay stable, req_ready_o stays 0, and no reg_en_o pulse occurs.
REQ-035 Write: requester 1 writes 0x4000 with data 0xFF -> reg_we_o=1, addr 0x4000, wdata 0xFF in cycle 1, response rdata 0.
REQ-036 Reset in RESP -> next cycle IDLE, all outputs 0, and the next grant goes to requester 0.

Source files
------------

// File: rtl/sy_clint_pkg.sv
// Shared types for the CLINT register-port arbiter: FSM states and the
// grant-index width helper.
package sy_clint_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sy_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr_i,
// wrapping around, as both a one-hot vector and an index.
module sy_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && valid_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    if (any_o) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/sy_clint_reg_arb.sv
// Round-robin arbiter funnelling several requesters onto the single CLINT
// register port: grant, one downstream access cycle, then a held response.
module sy_clint_reg_arb
  import sy_clint_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REQ_NUM    = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [REQ_NUM-1:0]                   req_valid_i,
  output logic [REQ_NUM-1:0]                   req_ready_o,
  input  logic [REQ_NUM-1:0]                   req_we_i,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  output logic [REQ_NUM-1:0]                   resp_valid_o,
  input  logic [REQ_NUM-1:0]                   resp_ready_i,
  output logic [DATA_WIDTH-1:0]                resp_rdata_o,
  output logic                                 reg_en_o,
  output logic                                 reg_we_o,
  output logic [ADDR_WIDTH-1:0]                reg_addr_o,
  output logic [DATA_WIDTH-1:0]                reg_wdata_o,
  input  logic [DATA_WIDTH-1:0]                reg_rdata_i
);

  localparam int IW = idx_width(REQ_NUM);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [REQ_NUM-1:0]    pick_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;

  sy_rr_pick #(
    .N  (REQ_NUM),
    .IW (IW)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          we_d    = req_we_i[pick_idx];
          addr_d  = req_addr_i[pick_idx];
          wdata_d = req_wdata_i[pick_idx];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = we_q ? '0 : reg_rdata_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready_i[gnt_q]) begin
          rr_ptr_d = (gnt_q == IW'(REQ_NUM - 1)) ? '0 : gnt_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs are masked while reset is high so an aborted cycle shows no handshake or strobe.
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    resp_rdata_o = '0;
    reg_en_o     = 1'b0;
    reg_we_o     = 1'b0;
    reg_addr_o   = '0;
    reg_wdata_o  = '0;
    if (!rst_i) begin
      case (state_q)
        ST_IDLE: req_ready_o = pick_oh;
        ST_ACCESS: begin
          reg_en_o    = 1'b1;
          reg_we_o    = we_q;
          reg_addr_o  = addr_q;
          reg_wdata_o = wdata_q;
        end
        ST_RESP: begin
          resp_valid_o[gnt_q] = 1'b1;
          resp_rdata_o        = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sy_clint_reg_arb.sv
// Directed bench for sy_clint_reg_arb: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_sy_clint_reg_arb;

  localparam int NR = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NR-1:0]        req_valid_i;
  logic [NR-1:0]        req_ready_o;
  logic [NR-1:0]        req_we_i;
  logic [NR-1:0][63:0]  req_addr_i;
  logic [NR-1:0][63:0]  req_wdata_i;
  logic [NR-1:0]        resp_valid_o;
  logic [NR-1:0]        resp_ready_i;
  logic [63:0]          resp_rdata_o;
  logic                 reg_en_o;
  logic                 reg_we_o;
  logic [63:0]          reg_addr_o;
  logic [63:0]          reg_wdata_o;
  logic [63:0]          reg_rdata_i;

  int vectorCount = 0;
  int missCount   = 0;

  sy_clint_reg_arb #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64),
    .REQ_NUM    (NR)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .reg_en_o     (reg_en_o),
    .reg_we_o     (reg_we_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_rdata_i  (reg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [NR-1:0] valid, input logic [NR-1:0] we,
                               input logic [NR-1:0] rready, input logic [63:0] rdata);
    waitCycle();
    rst_i        = rst;
    req_valid_i  = valid;
    req_we_i     = we;
    resp_ready_i = rready;
    reg_rdata_i  = rdata;
  endtask

  task automatic setRequest(input int idx, input logic [63:0] addr, input logic [63:0] wdata);
    req_addr_i[idx]  = addr;
    req_wdata_i[idx] = wdata;
  endtask

  // Transaction-level model: who holds the port, what it asked for, and
  // whether its single downstream cycle has happened yet.
  typedef struct {
    int          who;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } txn_t;

  txn_t mTxn;
  bit   mBusy       = 1'b0;
  bit   mAccessDone = 1'b0;
  int   mPtr        = 0;

  always @(negedge clk_i) begin
    int          pickIdx;
    logic [1:0]  expReady, expRvalid;
    logic [63:0] expRdata, expAddr, expWdata;
    logic        expEn, expWe;
    pickIdx = -1;
    for (int k = 0; k < NR; k++) begin
      if (pickIdx < 0 && req_valid_i[(mPtr + k) % NR]) pickIdx = (mPtr + k) % NR;
    end
    expReady = '0; expRvalid = '0; expRdata = '0; expAddr = '0; expWdata = '0;
    expEn = 1'b0; expWe = 1'b0;
    if (!rst_i) begin
      if (!mBusy) begin
        if (pickIdx >= 0) expReady = 2'(1 << pickIdx);
      end else if (!mAccessDone) begin
        expEn = 1'b1; expWe = mTxn.we; expAddr = mTxn.addr; expWdata = mTxn.wdata;
      end else begin
        expRvalid = 2'(1 << mTxn.who);
        expRdata  = mTxn.rdata;
      end
    end
    checkOutput("req_ready",  64'(req_ready_o),  64'(expReady));
    checkOutput("resp_valid", 64'(resp_valid_o), 64'(expRvalid));
    checkOutput("resp_rdata", resp_rdata_o,      expRdata);
    checkOutput("reg_en",     64'(reg_en_o),     64'(expEn));
    checkOutput("reg_we",     64'(reg_we_o),     64'(expWe));
    checkOutput("reg_addr",   reg_addr_o,        expAddr);
    checkOutput("reg_wdata",  reg_wdata_o,       expWdata);

    if (rst_i) begin
      mBusy = 1'b0; mAccessDone = 1'b0; mPtr = 0;
    end else if (!mBusy) begin
      if (pickIdx >= 0) begin
        mBusy       = 1'b1;
        mAccessDone = 1'b0;
        mTxn.who    = pickIdx;
        mTxn.we     = req_we_i[pickIdx];
        mTxn.addr   = req_addr_i[pickIdx];
        mTxn.wdata  = req_wdata_i[pickIdx];
        mTxn.rdata  = '0;
      end
    end else if (!mAccessDone) begin
      mTxn.rdata  = mTxn.we ? 64'h0 : reg_rdata_i;
      mAccessDone = 1'b1;
    end else if (resp_ready_i[mTxn.who]) begin
      mBusy = 1'b0;
      mPtr  = (mTxn.who + 1) % NR;
    end
  end

  int grantIdx[$];
  int grantCyc[$];

  initial begin
    rst_i = 1'b1; req_valid_i = '0; req_we_i = '0; resp_ready_i = '0;
    req_addr_i = '0; req_wdata_i = '0; reg_rdata_i = '0;

    // Reset holds every output low even with requests pending.
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b11, 64'h0);
    applyStimulus(1'b1, 2'b11, 2'b00, 2'b11, 64'h0);
    @(negedge clk_i);
    checkOutput("rst_ready", 64'(req_ready_o), 64'h0);
    checkOutput("rst_en",    64'(reg_en_o),    64'h0);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h0);

    // Single read by requester 0.
    setRequest(0, 64'hBFF8, 64'h0);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b11, 64'h1234);
    @(negedge clk_i);
    checkOutput("rd_ready", 64'(req_ready_o), 64'h1);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h1234);
    @(negedge clk_i);
    checkOutput("rd_en",   64'(reg_en_o), 64'h1);
    checkOutput("rd_we",   64'(reg_we_o), 64'h0);
    checkOutput("rd_addr", reg_addr_o,    64'hBFF8);
    waitCycle();
    @(negedge clk_i);
    checkOutput("rd_rvalid", 64'(resp_valid_o), 64'h1);
    checkOutput("rd_rdata",  resp_rdata_o,      64'h1234);
    waitCycle();
    @(negedge clk_i);
    checkOutput("rd_done", 64'(resp_valid_o), 64'h0);

    // Write by requester 1; reg_rdata_i is nonzero but the response must read 0.
    setRequest(1, 64'h4000, 64'hFF);
    applyStimulus(1'b0, 2'b10, 2'b10, 2'b11, 64'hDEAD);
    @(negedge clk_i);
    checkOutput("wr_ready", 64'(req_ready_o), 64'h2);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'hDEAD);
    @(negedge clk_i);
    checkOutput("wr_en",    64'(reg_en_o), 64'h1);
    checkOutput("wr_we",    64'(reg_we_o), 64'h1);
    checkOutput("wr_addr",  reg_addr_o,    64'h4000);
    checkOutput("wr_wdata", reg_wdata_o,   64'hFF);
    waitCycle();
    @(negedge clk_i);
    checkOutput("wr_rvalid", 64'(resp_valid_o), 64'h2);
    checkOutput("wr_rdata",  resp_rdata_o,      64'h0);

    // Contention: both valid for 12 cycles starting with pointer 0.
    setRequest(0, 64'h10, 64'hA);
    setRequest(1, 64'h18, 64'hB);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b11, 64'h55);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (req_ready_o != 2'b00) begin
        grantIdx.push_back(req_ready_o[1] ? 1 : 0);
        grantCyc.push_back(c);
      end
      if (c == 11) applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h55);
      else waitCycle();
    end
    checkOutput("cont_count", 64'(grantIdx.size()), 64'd4);
    for (int i = 0; i < grantIdx.size() && i < 4; i++) begin
      checkOutput($sformatf("cont_grant%0d", i), 64'(grantIdx[i]), 64'(i % 2));
      checkOutput($sformatf("cont_cycle%0d", i), 64'(grantCyc[i]), 64'(3 * i));
    end

    // Backpressure on requester 1; requester 0 arrives mid-transaction and must wait.
    setRequest(1, 64'h20, 64'h0);
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 64'hABCD);
    @(negedge clk_i);
    checkOutput("bp_ready", 64'(req_ready_o), 64'h2);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b01, 64'hABCD);
    @(negedge clk_i);
    checkOutput("bp_busy_ready", 64'(req_ready_o), 64'h0);
    for (int i = 0; i < 5; i++) begin
      waitCycle();
      @(negedge clk_i);
      checkOutput("bp_rvalid", 64'(resp_valid_o), 64'h2);
      checkOutput("bp_rdata",  resp_rdata_o,      64'hABCD);
      checkOutput("bp_ready0", 64'(req_ready_o),  64'h0);
      checkOutput("bp_en",     64'(reg_en_o),     64'h0);
    end
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b11, 64'hABCD);
    @(negedge clk_i);
    checkOutput("bp_hs_rvalid", 64'(resp_valid_o), 64'h2);
    waitCycle();
    @(negedge clk_i);
    checkOutput("bp_waiter_ready", 64'(req_ready_o), 64'h1);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h77);
    waitCycle();
    waitCycle();

    // Reset during RESP with pointer at 1: next grant must go to requester 0.
    setRequest(1, 64'h30, 64'h0);
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 64'h99);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 64'h99);
    waitCycle();
    @(negedge clk_i);
    checkOutput("rr_pre_rvalid", 64'(resp_valid_o), 64'h2);
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 64'h0);
    @(negedge clk_i);
    checkOutput("rr_rst_rvalid", 64'(resp_valid_o), 64'h0);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h0);
    @(negedge clk_i);
    checkOutput("rr_post_rvalid", 64'(resp_valid_o), 64'h0);
    checkOutput("rr_post_en",     64'(reg_en_o),     64'h0);
    checkOutput("rr_post_rdata",  resp_rdata_o,      64'h0);
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b11, 64'h5A);
    @(negedge clk_i);
    checkOutput("rr_post_grant", 64'(req_ready_o), 64'h1);

    // Reset during ACCESS aborts without a strobe or response.
    applyStimulus(1'b1, 2'b00, 2'b00, 2'b11, 64'h5A);
    @(negedge clk_i);
    checkOutput("ra_en", 64'(reg_en_o), 64'h0);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h0);
    @(negedge clk_i);
    checkOutput("ra_rvalid", 64'(resp_valid_o), 64'h0);
    waitCycle();
    @(negedge clk_i);
    checkOutput("ra_rvalid2", 64'(resp_valid_o), 64'h0);

    // Requester 1 pulses valid only while busy, so it is never granted.
    setRequest(0, 64'h40, 64'h0);
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b11, 64'h3);
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b11, 64'h3);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b11, 64'h3);
    waitCycle();
    @(negedge clk_i);
    checkOutput("drop_ready", 64'(req_ready_o), 64'h0);
    waitCycle();
    @(negedge clk_i);
    checkOutput("drop_en", 64'(reg_en_o), 64'h0);

    waitCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
